// File: rtl/bsg_manycore_loader_issue_buffer.sv
// Credit-gated issue buffer between the SPMD loader and the IO endpoint, with a drain-and-wait fence.
// Optional stall statistics counter and port: define BSG_LOADER_ISSUE_STALL_STATS_EN.
module bsg_manycore_loader_issue_buffer #(
   parameter int unsigned packet_width_p          = 32,
   parameter int unsigned els_p                   = 4,
   parameter int unsigned max_out_credits_p       = 200,
   parameter int unsigned credit_counter_width_lp = $clog2(max_out_credits_p + 1)
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               in_v_i,
   input  logic [packet_width_p-1:0]          in_packet_i,
   output logic                               in_ready_o,
   output logic                               out_v_o,
   output logic [packet_width_p-1:0]          out_packet_o,
   input  logic                               out_ready_i,
   input  logic [credit_counter_width_lp-1:0] out_credits_used_i,
   input  logic                               fence_i,
   output logic                               fence_done_o,
   output logic                               empty_o,
`ifdef BSG_LOADER_ISSUE_STALL_STATS_EN
   output logic [31:0]                        stall_cycles_o,
`endif
   output logic [31:0]                        issued_count_o
);

   localparam int unsigned ptr_w_lp = $clog2(els_p);
   localparam int unsigned cnt_w_lp = ptr_w_lp + 1;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [cnt_w_lp-1:0]       wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0]       rd_ptr_q, rd_ptr_d;
   logic [packet_width_p-1:0] mem_q [els_p];
   logic [31:0]               issued_q, issued_d;
   logic                      empty, full, credit_ok, enq, deq;

   // Pointers carry a wrap bit so full and empty are distinguishable at equal indices.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp])
                   && (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0]);
   assign credit_ok = (out_credits_used_i < credit_counter_width_lp'(max_out_credits_p));
   assign enq       = in_v_i & in_ready_o;
   assign deq       = out_v_o & out_ready_i;

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= S_RUN;
      else            state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RUN:   if (fence_i) state_d = S_DRAIN;
         S_DRAIN: if (empty) state_d = S_WAIT;
         S_WAIT:  if (out_credits_used_i == '0) state_d = S_DONE;
         S_DONE:  state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   // Output logic; issue is gated on outstanding credits in the same cycle.
   always_comb begin
      in_ready_o   = !full && (state_q == S_RUN);
      out_v_o      = !empty && credit_ok;
      out_packet_o = mem_q[rd_ptr_q[ptr_w_lp-1:0]];
      fence_done_o = (state_q == S_DONE);
      empty_o      = empty;
   end

   always_comb begin
      wr_ptr_d = enq ? wr_ptr_q + cnt_w_lp'(1) : wr_ptr_q;
      rd_ptr_d = deq ? rd_ptr_q + cnt_w_lp'(1) : rd_ptr_q;
      issued_d = deq ? issued_q + 32'd1 : issued_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         issued_q <= '0;
         for (int i = 0; i < int'(els_p); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         issued_q <= issued_d;
         if (enq) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= in_packet_i;
      end
   end

   assign issued_count_o = issued_q;

`ifdef BSG_LOADER_ISSUE_STALL_STATS_EN
   // Counts cycles where a buffered packet could not leave, saturating at all-ones.
   logic [31:0] stall_q, stall_d;
   logic        stall_inc;

   always_comb begin
      stall_inc = (!empty && !out_v_o) || (out_v_o && !out_ready_i);
      stall_d   = (stall_inc && (stall_q != '1)) ? stall_q + 32'd1 : stall_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) stall_q <= '0;
      else            stall_q <= stall_d;
   end

   assign stall_cycles_o = stall_q;
`endif

endmodule
